// File: rtl/iter_addsub_n.sv
// Iterative carry-save add/subtract: resolves a+b or a-b by repeated half-add
// passes, one per clock, until the carry vector drains to zero.
module iter_addsub_n #(
    parameter int N = 16,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [N-1:0]  a_i,
    input  logic [N-1:0]  b_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [N-1:0]  sum_o,
    output logic          cout_o,
    output logic          ovf_o,
    output logic [CW-1:0] iter_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  x_q, y_q;
    logic          cin_q;
    logic          a_msb_q, y_msb_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  sum_q;
    logic          cout_q, ovf_q;
    logic [CW-1:0] iter_q;

    logic          load_en, pass_en, finish;
    logic [N-1:0]  and_w;

    assign load_en = ((state_q == IDLE) || (state_q == DONE)) && start_i;
    assign pass_en = (state_q == RUN) && ((y_q != '0) || cin_q);
    assign finish  = (state_q == RUN) && !pass_en;
    assign and_w   = x_q & y_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? LOAD : IDLE;
            LOAD:    state_d = RUN;
            RUN:     state_d = pass_en ? RUN : DONE;
            DONE:    state_d = start_i ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags are decoded from the next state so they register in step with it.
    always_comb begin
        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q     <= '0;
            y_q     <= '0;
            cin_q   <= 1'b0;
            a_msb_q <= 1'b0;
            y_msb_q <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            if (load_en) begin
                x_q     <= a_i;
                y_q     <= mode_i ? ~b_i : b_i;
                cin_q   <= mode_i;
                a_msb_q <= a_i[N-1];
                y_msb_q <= mode_i ? ~b_i[N-1] : b_i[N-1];
                carry_q <= 1'b0;
                cnt_q   <= '0;
            end else if (pass_en) begin
                // The subtract carry-in rides into bit 0 on the first pass.
                x_q     <= x_q ^ y_q;
                y_q     <= {and_w[N-2:0], cin_q};
                cin_q   <= 1'b0;
                carry_q <= carry_q | and_w[N-1];
                cnt_q   <= cnt_q + CW'(1);
            end
            if (finish) begin
                sum_q  <= x_q;
                cout_q <= carry_q;
                ovf_q  <= (a_msb_q == y_msb_q) && (x_q[N-1] != a_msb_q);
                iter_q <= cnt_q;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
    assign iter_o = iter_q;

endmodule
